// File: rtl/fft_pkg.sv
// Shared constants and types for the in-place radix-2 DIT FFT control path.
package fft_pkg;

    localparam int FFT_N_LOG2   = 10;
    localparam int FFT_BFLY_LAT = 4;

    typedef logic [FFT_N_LOG2-1:0] fft_addr_t;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        DONE
    } fft_seq_state_e;

endpackage

// File: rtl/fft_addr_gen.sv
// Combinational map from (stage, butterfly index) to the two sample addresses
// and the twiddle ROM index of one radix-2 DIT butterfly.
module fft_addr_gen
    import fft_pkg::*;
#(
    parameter int N_LOG2 = FFT_N_LOG2
) (
    input  logic [3:0]        stage,
    input  logic [N_LOG2-2:0] k,
    output logic [N_LOG2-1:0] addr_a,
    output logic [N_LOG2-1:0] addr_b,
    output logic [N_LOG2-2:0] tw_idx
);

    localparam logic [3:0] TW_TOP = 4'(N_LOG2 - 1);

    logic [N_LOG2-1:0] k_ext;
    logic [N_LOG2-1:0] span;
    logic [N_LOG2-1:0] grp;
    logic [N_LOG2-1:0] pos;
    logic [N_LOG2-1:0] base;
    logic [N_LOG2-1:0] tw_wide;
    logic [3:0]        tw_shift;

    // Groups of 2*span samples; pos selects the pair inside the group and
    // also scales the twiddle exponent so later stages use finer angles.
    always_comb begin
        k_ext    = {1'b0, k};
        span     = {{(N_LOG2-1){1'b0}}, 1'b1} << stage;
        grp      = k_ext >> stage;
        pos      = k_ext & (span - {{(N_LOG2-1){1'b0}}, 1'b1});
        base     = (grp << (stage + 4'd1)) | pos;
        tw_shift = TW_TOP - stage;
        tw_wide  = pos << tw_shift;
        addr_a   = base;
        addr_b   = base + span;
        tw_idx   = tw_wide[N_LOG2-2:0];
    end

endmodule

// File: rtl/fft_stage_sequencer.sv
// Stage/butterfly sequencer for the in-place FFT: issues read addresses and
// twiddle indices, delays them into write-back addresses, drains between stages.
module fft_stage_sequencer
    import fft_pkg::*;
#(
    parameter int N_LOG2   = FFT_N_LOG2,
    parameter int BFLY_LAT = FFT_BFLY_LAT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stall,
    output logic              busy,
    output logic              done,
    output logic [3:0]        stage,
    output logic              bfly_valid,
    output logic [N_LOG2-1:0] rd_addr_a,
    output logic [N_LOG2-1:0] rd_addr_b,
    output logic [N_LOG2-2:0] tw_idx,
    output logic              wr_en,
    output logic [N_LOG2-1:0] wr_addr_a,
    output logic [N_LOG2-1:0] wr_addr_b
);

    localparam int              K_W        = N_LOG2 - 1;
    localparam int              CNT_W      = $clog2(BFLY_LAT + 1);
    localparam logic [K_W-1:0]  K_LAST     = '1;
    localparam logic [3:0]      STAGE_LAST = 4'(N_LOG2 - 1);
    localparam logic [CNT_W-1:0] DRAIN_INIT = CNT_W'(BFLY_LAT);
    localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(1);

    typedef struct packed {
        logic              valid;
        logic [N_LOG2-1:0] a;
        logic [N_LOG2-1:0] b;
    } wb_t;

    fft_seq_state_e    state;
    logic [K_W-1:0]    k;
    logic [CNT_W-1:0]  drain_cnt;
    logic [N_LOG2-1:0] gen_a;
    logic [N_LOG2-1:0] gen_b;
    logic [K_W-1:0]    gen_tw;
    wb_t               wb_pipe [BFLY_LAT];

    fft_addr_gen #(
        .N_LOG2 (N_LOG2)
    ) u_addr_gen (
        .stage  (stage),
        .k      (k),
        .addr_a (gen_a),
        .addr_b (gen_b),
        .tw_idx (gen_tw)
    );

    // k holds at its last value through DRAIN and only wraps on the stage change.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            stage      <= '0;
            k          <= '0;
            drain_cnt  <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            bfly_valid <= 1'b0;
            rd_addr_a  <= '0;
            rd_addr_b  <= '0;
            tw_idx     <= '0;
        end else begin
            done       <= 1'b0;
            bfly_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= ISSUE;
                        stage <= '0;
                        k     <= '0;
                        busy  <= 1'b1;
                    end
                end
                ISSUE: begin
                    if (!stall) begin
                        bfly_valid <= 1'b1;
                        rd_addr_a  <= gen_a;
                        rd_addr_b  <= gen_b;
                        tw_idx     <= gen_tw;
                        if (k == K_LAST) begin
                            state     <= DRAIN;
                            drain_cnt <= DRAIN_INIT;
                        end else begin
                            k <= k + K_W'(1);
                        end
                    end
                end
                DRAIN: begin
                    drain_cnt <= drain_cnt - DRAIN_LAST;
                    if (drain_cnt == DRAIN_LAST) begin
                        if (stage < STAGE_LAST) begin
                            state <= ISSUE;
                            stage <= stage + 4'd1;
                            k     <= '0;
                        end else begin
                            state <= DONE;
                            busy  <= 1'b0;
                        end
                    end
                end
                DONE: begin
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // The butterfly pipeline never stalls, so the write-back line shifts every cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < BFLY_LAT; i++) begin
                wb_pipe[i] <= '0;
            end
        end else begin
            wb_pipe[0] <= wb_t'{valid: bfly_valid, a: rd_addr_a, b: rd_addr_b};
            for (int i = 1; i < BFLY_LAT; i++) begin
                wb_pipe[i] <= wb_pipe[i-1];
            end
        end
    end

    assign wr_en     = wb_pipe[BFLY_LAT-1].valid;
    assign wr_addr_a = wb_pipe[BFLY_LAT-1].a;
    assign wr_addr_b = wb_pipe[BFLY_LAT-1].b;

endmodule

// File: tb/tb_fft_stage_sequencer.sv
// Scoreboard bench for fft_stage_sequencer: expected issues, write-backs and
// done cycles are queued by the stimulus and consumed by a negedge monitor.
module tb_fft_stage_sequencer;

    logic       clk;
    logic       rst;
    logic       start;
    logic       stall;
    logic       start_sw;

    logic       busy, done, bfly_valid, wr_en;
    logic [3:0] stage;
    logic [9:0] rd_addr_a, rd_addr_b, wr_addr_a, wr_addr_b;
    logic [8:0] tw_idx;

    logic       busy1, done1, bv1, wr1;
    logic [3:0] stage1;
    logic [9:0] ra1, rb1, wa1, wb1;
    logic [8:0] tw1;

    logic       busy7, done7, bv7, wr7;
    logic [3:0] stage7;
    logic [9:0] ra7, rb7, wa7, wb7;
    logic [8:0] tw7;

    typedef struct {
        int s;
        int k;
        int a;
        int b;
        int tw;
    } rd_exp_t;

    typedef struct {
        int a;
        int b;
        int t;
    } wr_exp_t;

    rd_exp_t exp_rd[$];
    wr_exp_t exp_wr[$];
    int      exp_done[$];
    int      exp_done1[$];
    int      exp_done7[$];

    int cyc = 0;
    int checks = 0;
    int passes = 0;
    int e0 = 0;
    int wr_count = 0;
    int wr_count1 = 0;
    int wr_count7 = 0;
    int first_issue_cyc = -1;
    int last_issue_stage = -1;
    logic [28:0] cap_s0k0, cap_s0k1, cap_s1k3, cap_s9k511;

    fft_stage_sequencer #(.N_LOG2(10), .BFLY_LAT(4)) dut (
        .clk(clk), .rst(rst), .start(start), .stall(stall),
        .busy(busy), .done(done), .stage(stage), .bfly_valid(bfly_valid),
        .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .tw_idx(tw_idx),
        .wr_en(wr_en), .wr_addr_a(wr_addr_a), .wr_addr_b(wr_addr_b)
    );

    fft_stage_sequencer #(.N_LOG2(10), .BFLY_LAT(1)) dut_lat1 (
        .clk(clk), .rst(rst), .start(start_sw), .stall(1'b0),
        .busy(busy1), .done(done1), .stage(stage1), .bfly_valid(bv1),
        .rd_addr_a(ra1), .rd_addr_b(rb1), .tw_idx(tw1),
        .wr_en(wr1), .wr_addr_a(wa1), .wr_addr_b(wb1)
    );

    fft_stage_sequencer #(.N_LOG2(10), .BFLY_LAT(7)) dut_lat7 (
        .clk(clk), .rst(rst), .start(start_sw), .stall(1'b0),
        .busy(busy7), .done(done7), .stage(stage7), .bfly_valid(bv7),
        .rd_addr_a(ra7), .rd_addr_b(rb7), .tw_idx(tw7),
        .wr_en(wr7), .wr_addr_a(wa7), .wr_addr_b(wb7)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end else begin
            passes++;
        end
    endtask

    // Reference address math written with divide/modulo rather than shifts.
    function automatic rd_exp_t model(input int s, input int k);
        rd_exp_t e;
        int span;
        span = 1 << s;
        e.s  = s;
        e.k  = k;
        e.a  = (k / span) * (2 * span) + (k % span);
        e.b  = e.a + span;
        e.tw = (k % span) * (512 / span);
        return e;
    endfunction

    task automatic wait_until_edge(input int edge_n);
        while (cyc < edge_n - 1) @(negedge clk);
    endtask

    // Pulse start on the next edge and queue the full expected transform.
    task automatic apply_stimulus(input int extra_cycles);
        start            = 1'b1;
        e0               = cyc + 1;
        wr_count         = 0;
        first_issue_cyc  = -1;
        last_issue_stage = -1;
        for (int s = 0; s < 10; s++) begin
            for (int k = 0; k < 512; k++) begin
                exp_rd.push_back(model(s, k));
            end
        end
        exp_done.push_back(e0 + 5161 + extra_cycles);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        while (exp_done.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check_output("done_seen", 64'(exp_done.size()), 64'd0);
        check_output("reads_consumed", 64'(exp_rd.size()), 64'd0);
        check_output("writes_consumed", 64'(exp_wr.size()), 64'd0);
        check_output("busy_after_done", {63'd0, busy}, 64'd0);
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        rd_exp_t e;
        wr_exp_t w;
        int      d;
        if (bfly_valid) begin
            if (exp_rd.size() == 0) begin
                check_output("unexpected_issue", {54'd0, rd_addr_a}, 64'h3ff_ffff);
            end else begin
                e = exp_rd.pop_front();
                check_output("rd_issue", {31'd0, stage, rd_addr_a, rd_addr_b, tw_idx},
                             {31'd0, 4'(e.s), 10'(e.a), 10'(e.b), 9'(e.tw)});
                if (first_issue_cyc < 0) first_issue_cyc = cyc;
                if (e.s != last_issue_stage) begin
                    check_output("raw_hazard_pending_writes", 64'(exp_wr.size()), 64'd0);
                    last_issue_stage = e.s;
                end
                if (e.s == 0 && e.k == 0)   cap_s0k0   = {rd_addr_a, rd_addr_b, tw_idx};
                if (e.s == 0 && e.k == 1)   cap_s0k1   = {rd_addr_a, rd_addr_b, tw_idx};
                if (e.s == 1 && e.k == 3)   cap_s1k3   = {rd_addr_a, rd_addr_b, tw_idx};
                if (e.s == 9 && e.k == 511) cap_s9k511 = {rd_addr_a, rd_addr_b, tw_idx};
                exp_wr.push_back('{a: e.a, b: e.b, t: cyc + 4});
            end
        end
        if (wr_en) begin
            wr_count++;
            if (exp_wr.size() == 0) begin
                check_output("unexpected_wr_en", {54'd0, wr_addr_a}, 64'h3ff_ffff);
            end else begin
                w = exp_wr.pop_front();
                check_output("wr_back", {12'd0, wr_addr_a, wr_addr_b, 32'(cyc)},
                             {12'd0, 10'(w.a), 10'(w.b), 32'(w.t)});
            end
        end
        if (done) begin
            if (exp_done.size() == 0) begin
                check_output("unexpected_done", 64'(cyc), 64'hffff_ffff);
            end else begin
                d = exp_done.pop_front();
                check_output("done_cycle", 64'(cyc), 64'(d));
            end
        end
        if (wr1) wr_count1++;
        if (wr7) wr_count7++;
        if (done1) begin
            if (exp_done1.size() == 0) check_output("unexpected_done_lat1", 64'(cyc), 64'hffff_ffff);
            else begin
                d = exp_done1.pop_front();
                check_output("done_cycle_lat1", 64'(cyc), 64'(d));
            end
        end
        if (done7) begin
            if (exp_done7.size() == 0) check_output("unexpected_done_lat7", 64'(cyc), 64'hffff_ffff);
            else begin
                d = exp_done7.pop_front();
                check_output("done_cycle_lat7", 64'(cyc), 64'(d));
            end
        end
    end

    initial begin
        int x;
        int n;
        rst      = 1'b1;
        start    = 1'b0;
        stall    = 1'b0;
        start_sw = 1'b0;
        cap_s0k0   = '1;
        cap_s0k1   = '1;
        cap_s1k3   = '1;
        cap_s9k511 = '1;
        repeat (3) @(negedge clk);
        check_output("reset_state", {7'd0, busy, done, stage, bfly_valid, rd_addr_a, rd_addr_b,
                     tw_idx, wr_en, wr_addr_a, wr_addr_b}, 64'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Plain transform with hand-computed address spot checks.
        $display("[TB] run A: plain transform");
        apply_stimulus(0);
        wait_until_edge(e0 + 6);
        check_output("busy_during_run", {63'd0, busy}, 64'd1);
        wait_done(6000);
        check_output("first_issue_cycle", 64'(first_issue_cyc), 64'(e0 + 1));
        check_output("wr_count", 64'(wr_count), 64'd5120);
        check_output("vec_s0_k0", {35'd0, cap_s0k0}, {35'd0, 10'd0, 10'd1, 9'd0});
        check_output("vec_s0_k1", {35'd0, cap_s0k1}, {35'd0, 10'd2, 10'd3, 9'd0});
        check_output("vec_s1_k3", {35'd0, cap_s1k3}, {35'd0, 10'd5, 10'd7, 9'd256});
        check_output("vec_s9_k511", {35'd0, cap_s9k511}, {35'd0, 10'd511, 10'd1023, 9'd511});

        // Stalls mid-stage 2 and on stage 5's last butterfly, plus a stray start.
        $display("[TB] run B: stalls and start while busy");
        apply_stimulus(5);
        x = e0 + 1 + 2 * 516 + 100;
        wait_until_edge(x);
        stall = 1'b1;
        wait_until_edge(x + 3);
        stall = 1'b0;
        x = e0 + 1 + 5 * 516 + 511 + 3;
        wait_until_edge(x);
        stall = 1'b1;
        wait_until_edge(x + 2);
        stall = 1'b0;
        wait_until_edge(e0 + 3000);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(6000);
        check_output("wr_count_stall", 64'(wr_count), 64'd5120);

        // Start while stall is held: first issue waits for stall to drop.
        $display("[TB] run C: start under stall");
        stall = 1'b1;
        apply_stimulus(3);
        wait_until_edge(e0 + 4);
        stall = 1'b0;
        wait_done(6000);
        check_output("first_issue_after_stall", 64'(first_issue_cyc), 64'(e0 + 4));

        // Reset in the drain of stage 4, then a clean full transform.
        $display("[TB] run D: reset during drain");
        apply_stimulus(0);
        wait_until_edge(e0 + 1 + 4 * 516 + 511 + 2);
        rst = 1'b1;
        @(negedge clk);
        check_output("rst_outputs", {7'd0, busy, done, stage, bfly_valid, rd_addr_a, rd_addr_b,
                     tw_idx, wr_en, wr_addr_a, wr_addr_b}, 64'd0);
        rst = 1'b0;
        exp_rd.delete();
        exp_wr.delete();
        exp_done.delete();
        wr_count = 0;
        repeat (12) @(negedge clk);
        check_output("no_wr_after_rst", 64'(wr_count), 64'd0);
        apply_stimulus(0);
        wait_done(6000);
        check_output("wr_count_after_rst", 64'(wr_count), 64'd5120);

        // Latency sweep on the BFLY_LAT=1 and BFLY_LAT=7 instances.
        $display("[TB] run E: latency sweep");
        wr_count1 = 0;
        wr_count7 = 0;
        start_sw  = 1'b1;
        exp_done1.push_back(cyc + 1 + 5131);
        exp_done7.push_back(cyc + 1 + 5191);
        @(negedge clk);
        start_sw = 1'b0;
        n = 0;
        while ((exp_done1.size() != 0 || exp_done7.size() != 0) && n < 6000) begin
            @(negedge clk);
            n++;
        end
        check_output("done_seen_lat1", 64'(exp_done1.size()), 64'd0);
        check_output("done_seen_lat7", 64'(exp_done7.size()), 64'd0);
        check_output("wr_count_lat1", 64'(wr_count1), 64'd5120);
        check_output("wr_count_lat7", 64'(wr_count7), 64'd5120);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
